// File: rtl/scaler_pkg.sv
// Shared constants and arithmetic for the line scaler: output mode codes, the
// scale-factor legality check and the per-channel horizontal blend.
package scaler_pkg;

    localparam logic [1:0] MODE_NEAREST = 2'd0;
    localparam logic [1:0] MODE_HBLEND  = 2'd1;
    localparam logic [1:0] MODE_SCAN    = 2'd2;
    localparam logic [1:0] MODE_BOTH    = 2'd3;

    function automatic bit scale_ok(input int unsigned scale);
        return (scale == 32'd2) || (scale == 32'd4);
    endfunction

    // Weighted mix of a and b at sub-pixel s; scale is 2 or 4 so the divide is a shift.
    function automatic int unsigned blend_ch(input int unsigned a, input int unsigned b,
                                             input int unsigned s, input int unsigned scale);
        int unsigned sh;
        sh = (scale == 32'd4) ? 32'd2 : 32'd1;
        return (a * (scale - s) + b * s) >> sh;
    endfunction

endpackage

// File: rtl/line_scaler_buf.sv
// One half of the ping-pong line store: simple dual-port RAM with a registered read
// that holds its value while no read is requested.
module line_scaler_buf #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 24
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_scaler.sv
// Integer line scaler: captures each input line into a ping-pong buffer and replays the
// previous line SCALE times in both directions, with optional blend and scanline shading.
module line_scaler
    import scaler_pkg::*;
#(
    parameter int unsigned LENGTH = 256,
    parameter int unsigned CW     = 8,
    parameter int unsigned CH     = 3,
    parameter int unsigned SCALE  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce_in,
    input  logic [CH*CW-1:0] pxl_in,
    input  logic             line_start,
    input  logic             frame_start,
    input  logic [1:0]       mode,
    input  logic             ce_out,
    input  logic             hblank_out,
    input  logic [1:0]       row_sel,
    output logic [CH*CW-1:0] pxl_out
);

    localparam int unsigned PW = CH * CW;
    localparam int unsigned AW = $clog2(LENGTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned SW = $clog2(SCALE);

    if (!scale_ok(SCALE)) begin : g_bad_scale
        $error("line_scaler: SCALE must be 2 or 4");
    end

    logic          wr_buf_q, wr_buf_d;
    logic [LW-1:0] wr_addr_q, wr_addr_d;
    logic [LW-1:0] last_len_q, last_len_d;
    logic          ls_prev_q, ls_prev_d;
    logic          fs_prev_q, fs_prev_d;
    logic [1:0]    mode_q, mode_d;
    logic          rd_buf_q, rd_buf_d;
    logic [LW-1:0] rd_len_q, rd_len_d;
    logic [AW-1:0] p_q, p_d;
    logic [SW-1:0] s_q, s_d;
    logic [PW-1:0] cur_q, cur_d;
    logic          pf_q, pf_d;
    logic          fetch_q, fetch_d;
    logic [PW-1:0] pxl_out_q, pxl_out_d;

    logic          ls_edge, fs_edge;
    logic          we, wsel, re;
    logic [AW-1:0] waddr, raddr;
    logic [PW-1:0] rdata [2];
    logic [PW-1:0] rd_mux, nbr, mix;
    logic [LW-1:0] p_ext;
    logic          in_line, scan_row, blend_on;

    for (genvar i = 0; i < 2; i++) begin : g_buf
        line_scaler_buf #(
            .DEPTH(LENGTH),
            .WIDTH(PW)
        ) u_buf (
            .clk_i  (clk),
            .we_i   (we && (wsel == 1'(i))),
            .waddr_i(waddr),
            .wdata_i(pxl_in),
            .re_i   (re),
            .raddr_i(raddr),
            .rdata_o(rdata[i])
        );
    end

    // The RAM output register of the read buffer doubles as the nxt pixel register.
    assign rd_mux   = rd_buf_q ? rdata[1] : rdata[0];
    assign p_ext    = {1'b0, p_q};
    assign in_line  = p_ext < rd_len_q;
    assign nbr      = ((p_ext + LW'(1)) >= rd_len_q) ? cur_q : rd_mux;
    assign blend_on = (mode_q == MODE_HBLEND) || (mode_q == MODE_BOTH);
    assign scan_row = ((mode_q == MODE_SCAN) || (mode_q == MODE_BOTH)) &&
                      (row_sel == 2'(SCALE - 1));

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [CW-1:0] a, b, bl, sel;
        assign a   = cur_q[c*CW +: CW];
        assign b   = nbr[c*CW +: CW];
        assign bl  = CW'(blend_ch(32'(a), 32'(b), 32'(s_q), SCALE));
        assign sel = blend_on ? bl : a;
        assign mix[c*CW +: CW] = scan_row ? (sel >> 1) : sel;
    end

    always_comb begin
        wr_buf_d   = wr_buf_q;
        wr_addr_d  = wr_addr_q;
        last_len_d = last_len_q;
        ls_prev_d  = ls_prev_q;
        fs_prev_d  = fs_prev_q;
        mode_d     = mode_q;
        we         = 1'b0;
        wsel       = wr_buf_q;
        waddr      = wr_addr_q[AW-1:0];
        ls_edge    = ce_in && line_start && !ls_prev_q;
        fs_edge    = ce_in && frame_start && !fs_prev_q;

        if (ce_in) begin
            ls_prev_d = line_start;
            fs_prev_d = frame_start;
            if (ls_edge) begin
                wr_buf_d   = ~wr_buf_q;
                wsel       = ~wr_buf_q;
                last_len_d = wr_addr_q;
                we         = 1'b1;
                waddr      = '0;
                wr_addr_d  = LW'(1);
            end else if (wr_addr_q < LW'(LENGTH)) begin
                we        = 1'b1;
                wr_addr_d = wr_addr_q + LW'(1);
            end
            // A frame edge wins over a coincident line edge for the stored length.
            if (fs_edge) begin
                last_len_d = '0;
                mode_d     = mode;
            end
        end
    end

    always_comb begin
        rd_buf_d  = rd_buf_q;
        rd_len_d  = rd_len_q;
        p_d       = p_q;
        s_d       = s_q;
        cur_d     = cur_q;
        pf_d      = pf_q;
        fetch_d   = fetch_q;
        pxl_out_d = pxl_out_q;
        re        = 1'b0;
        raddr     = '0;

        if (ce_out && hblank_out) begin
            rd_buf_d  = ~wr_buf_q;
            rd_len_d  = last_len_q;
            p_d       = '0;
            s_d       = '0;
            pxl_out_d = '0;
            pf_d      = 1'b1;
            fetch_d   = 1'b0;
            re        = 1'b1;
        end else if (ce_out) begin
            pxl_out_d = in_line ? mix : '0;
            if (s_q == SW'(SCALE - 1)) begin
                s_d = '0;
                if (p_q != AW'(LENGTH - 1)) begin
                    p_d     = p_q + AW'(1);
                    cur_d   = rd_mux;
                    fetch_d = 1'b1;
                end
            end else begin
                s_d = s_q + SW'(1);
            end
        end else if (pf_q) begin
            re    = 1'b1;
            raddr = AW'(1);
            cur_d = rd_mux;
            pf_d  = 1'b0;
        end else if (fetch_q) begin
            re      = 1'b1;
            raddr   = p_q + AW'(1);
            fetch_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_buf_q   <= 1'b0;
            wr_addr_q  <= '0;
            last_len_q <= '0;
            ls_prev_q  <= 1'b0;
            fs_prev_q  <= 1'b0;
            mode_q     <= MODE_NEAREST;
            rd_buf_q   <= 1'b0;
            rd_len_q   <= '0;
            p_q        <= '0;
            s_q        <= '0;
            cur_q      <= '0;
            pf_q       <= 1'b0;
            fetch_q    <= 1'b0;
            pxl_out_q  <= '0;
        end else begin
            wr_buf_q   <= wr_buf_d;
            wr_addr_q  <= wr_addr_d;
            last_len_q <= last_len_d;
            ls_prev_q  <= ls_prev_d;
            fs_prev_q  <= fs_prev_d;
            mode_q     <= mode_d;
            rd_buf_q   <= rd_buf_d;
            rd_len_q   <= rd_len_d;
            p_q        <= p_d;
            s_q        <= s_d;
            cur_q      <= cur_d;
            pf_q       <= pf_d;
            fetch_q    <= fetch_d;
            pxl_out_q  <= pxl_out_d;
        end
    end

    assign pxl_out = pxl_out_q;

endmodule

// File: tb/tb_line_scaler.sv
// Bench for line_scaler: x2 and x4 instances share stimulus; a reference model of the
// writer and reader predicts each output pixel into per-instance scoreboard queues.
module tb_line_scaler;

    localparam int unsigned LEN = 16;
    localparam int unsigned CW  = 8;
    localparam int unsigned CH  = 3;
    localparam int unsigned PW  = CH * CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce_in = 1'b0;
    logic [PW-1:0] pxl_in = '0;
    logic          line_start = 1'b0;
    logic          frame_start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          ce_out = 1'b0;
    logic          hblank_out = 1'b1;
    logic [1:0]    row_sel = 2'd0;
    logic [PW-1:0] pxl_out2, pxl_out4;

    int errors = 0;
    int checks = 0;

    logic [PW-1:0] q2[$];
    logic [PW-1:0] q4[$];

    logic [PW-1:0] m_mem [2][LEN];
    int   m_wr_buf, m_wr_addr, m_last_len, m_mode;
    logic m_ls_prev, m_fs_prev;
    int   m_rd_buf [2];
    int   m_rd_len [2];
    int   m_p [2];
    int   m_s [2];

    always #5 clk = ~clk;

    line_scaler #(.LENGTH(LEN), .CW(CW), .CH(CH), .SCALE(2)) u_dut2 (
        .clk(clk), .rst(rst), .ce_in(ce_in), .pxl_in(pxl_in), .line_start(line_start),
        .frame_start(frame_start), .mode(mode), .ce_out(ce_out), .hblank_out(hblank_out),
        .row_sel(row_sel), .pxl_out(pxl_out2)
    );

    line_scaler #(.LENGTH(LEN), .CW(CW), .CH(CH), .SCALE(4)) u_dut4 (
        .clk(clk), .rst(rst), .ce_in(ce_in), .pxl_in(pxl_in), .line_start(line_start),
        .frame_start(frame_start), .mode(mode), .ce_out(ce_out), .hblank_out(hblank_out),
        .row_sel(row_sel), .pxl_out(pxl_out4)
    );

    function automatic logic [PW-1:0] exp_pix(input int k, input int row);
        int sc, sh, p, s, len, v;
        logic [PW-1:0] a, b, r;
        sc  = (k == 0) ? 2 : 4;
        sh  = (k == 0) ? 1 : 2;
        p   = m_p[k];
        s   = m_s[k];
        len = m_rd_len[k];
        r   = '0;
        if (p < len) begin
            a = m_mem[m_rd_buf[k]][p];
            b = a;
            if (p + 1 < len) b = m_mem[m_rd_buf[k]][p + 1];
            for (int c = 0; c < CH; c++) begin
                v = int'(a[c*CW +: CW]);
                if (m_mode == 1 || m_mode == 3) v = (v * (sc - s) + int'(b[c*CW +: CW]) * s) >> sh;
                if ((m_mode == 2 || m_mode == 3) && row == sc - 1) v = v >> 1;
                r[c*CW +: CW] = CW'(v);
            end
        end
        return r;
    endfunction

    task automatic drive_in(input logic [PW-1:0] px, input logic ls, input logic fs);
        ce_in = 1'b1; pxl_in = px; line_start = ls; frame_start = fs;
        if (ls && !m_ls_prev) begin
            m_wr_buf = 1 - m_wr_buf;
            m_last_len = m_wr_addr;
            m_mem[m_wr_buf][0] = px;
            m_wr_addr = 1;
        end else if (m_wr_addr < LEN) begin
            m_mem[m_wr_buf][m_wr_addr] = px;
            m_wr_addr++;
        end
        if (fs && !m_fs_prev) begin
            m_last_len = 0;
            m_mode = int'(mode);
        end
        m_ls_prev = ls; m_fs_prev = fs;
        @(posedge clk); #1;
        ce_in = 1'b0;
    endtask

    task automatic write_line(input int n, input logic [PW-1:0] base, input logic [PW-1:0] step);
        for (int i = 0; i < n; i++) drive_in(base + PW'(i) * step, i == 0, 1'b0);
    endtask

    task automatic swap_line();
        drive_in(24'hA5A5A5, 1'b1, 1'b0);
        drive_in(24'h5A5A5A, 1'b0, 1'b0);
    endtask

    task automatic start_frame(input logic [1:0] m, input logic with_ls);
        mode = m;
        drive_in(24'h3C3C3C, with_ls, 1'b1);
        drive_in(24'hC3C3C3, 1'b0, 1'b0);
    endtask

    // One ce_out pulse with an idle clk before it; predictions go into the scoreboards.
    task automatic pulse_out(input logic hb, input int row);
        logic [PW-1:0] px;
        int sc;
        @(posedge clk); #1;
        row_sel = 2'(row); hblank_out = hb; ce_out = 1'b1;
        for (int k = 0; k < 2; k++) begin
            sc = (k == 0) ? 2 : 4;
            if (hb) begin
                m_rd_buf[k] = 1 - m_wr_buf;
                m_rd_len[k] = m_last_len;
                m_p[k] = 0; m_s[k] = 0;
                px = '0;
            end else begin
                px = exp_pix(k, row);
                if (m_s[k] == sc - 1) begin
                    m_s[k] = 0;
                    if (m_p[k] < LEN - 1) m_p[k]++;
                end else begin
                    m_s[k]++;
                end
            end
            if (k == 0) q2.push_back(px);
            else q4.push_back(px);
        end
        @(posedge clk); #1;
        ce_out = 1'b0;
    endtask

    task automatic test_reset();
        logic [PW-1:0] e2, e4;
        rst = 1'b1;
        m_wr_buf = 0; m_wr_addr = 0; m_last_len = 0; m_mode = 0;
        m_ls_prev = 1'b0; m_fs_prev = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks += 2;
        if (pxl_out2 !== '0) begin errors++; $display("FAIL reset x2: got %h want 0", pxl_out2); end
        if (pxl_out4 !== '0) begin errors++; $display("FAIL reset x4: got %h want 0", pxl_out4); end
        for (int i = 0; i <= 6; i++) begin
            pulse_out(i == 0, 0);
            e2 = q2.pop_front(); e4 = q4.pop_front(); checks += 2;
            if (pxl_out2 !== e2) begin errors++; $display("FAIL reset_line x2 i%0d: got %h want %h", i, pxl_out2, e2); end
            if (pxl_out4 !== e4) begin errors++; $display("FAIL reset_line x4 i%0d: got %h want %h", i, pxl_out4, e4); end
        end
        // mode input ignored until a frame edge: reset mode must be nearest
        mode = 2'd3;
        write_line(3, 24'h405060, 24'h102030);
        swap_line();
        for (int i = 0; i <= 8; i++) begin
            pulse_out(i == 0, 1);
            e2 = q2.pop_front(); e4 = q4.pop_front(); checks += 2;
            if (pxl_out2 !== e2) begin errors++; $display("FAIL reset_mode x2 i%0d: got %h want %h", i, pxl_out2, e2); end
            if (pxl_out4 !== e4) begin errors++; $display("FAIL reset_mode x4 i%0d: got %h want %h", i, pxl_out4, e4); end
        end
    endtask

    task automatic test_nearest();
        logic [PW-1:0] e2, e4;
        start_frame(2'd0, 1'b0);
        write_line(3, 24'h031010, 24'h010010);
        swap_line();
        for (int row = 0; row < 2; row++) begin
            for (int i = 0; i <= 16; i++) begin
                pulse_out(i == 0, row);
                e2 = q2.pop_front(); e4 = q4.pop_front(); checks += 2;
                if (pxl_out2 !== e2) begin errors++; $display("FAIL nearest x2 r%0d i%0d: got %h want %h", row, i, pxl_out2, e2); end
                if (pxl_out4 !== e4) begin errors++; $display("FAIL nearest x4 r%0d i%0d: got %h want %h", row, i, pxl_out4, e4); end
            end
        end
    endtask

    task automatic test_hblend();
        logic [PW-1:0] e2, e4;
        start_frame(2'd1, 1'b0);
        write_line(2, 24'h000000, 24'h808080);
        swap_line();
        for (int i = 0; i <= 12; i++) begin
            pulse_out(i == 0, 0);
            e2 = q2.pop_front(); e4 = q4.pop_front(); checks += 2;
            if (pxl_out2 !== e2) begin errors++; $display("FAIL hblend x2 i%0d: got %h want %h", i, pxl_out2, e2); end
            if (pxl_out4 !== e4) begin errors++; $display("FAIL hblend x4 i%0d: got %h want %h", i, pxl_out4, e4); end
        end
    endtask

    task automatic test_scanline();
        logic [PW-1:0] e2, e4;
        start_frame(2'd2, 1'b0);
        write_line(2, 24'hFFFFFF, 24'h020406);
        swap_line();
        for (int row = 0; row < 2; row++) begin
            for (int i = 0; i <= 6; i++) begin
                pulse_out(i == 0, row);
                e2 = q2.pop_front(); e4 = q4.pop_front(); checks += 2;
                if (pxl_out2 !== e2) begin errors++; $display("FAIL scanline x2 r%0d i%0d: got %h want %h", row, i, pxl_out2, e2); end
                if (pxl_out4 !== e4) begin errors++; $display("FAIL scanline x4 r%0d i%0d: got %h want %h", row, i, pxl_out4, e4); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] e2, e4;
        start_frame(2'd3, 1'b0);
        write_line(4, 24'h204060, 24'h302010);
        swap_line();
        for (int row = 0; row < 4; row++) begin
            for (int i = 0; i <= 17; i++) begin
                pulse_out(i == 0, row);
                e2 = q2.pop_front(); e4 = q4.pop_front(); checks += 2;
                if (pxl_out2 !== e2) begin errors++; $display("FAIL both x2 r%0d i%0d: got %h want %h", row, i, pxl_out2, e2); end
                if (pxl_out4 !== e4) begin errors++; $display("FAIL both x4 r%0d i%0d: got %h want %h", row, i, pxl_out4, e4); end
            end
        end
    endtask

    task automatic test_saturate();
        logic [PW-1:0] e2, e4;
        start_frame(2'd0, 1'b0);
        write_line(LEN + 5, 24'h404040, 24'h010203);
        swap_line();
        for (int i = 0; i <= 64; i++) begin
            pulse_out(i == 0, 0);
            e2 = q2.pop_front(); e4 = q4.pop_front(); checks += 2;
            if (pxl_out2 !== e2) begin errors++; $display("FAIL saturate x2 i%0d: got %h want %h", i, pxl_out2, e2); end
            if (pxl_out4 !== e4) begin errors++; $display("FAIL saturate x4 i%0d: got %h want %h", i, pxl_out4, e4); end
        end
    endtask

    task automatic test_mode_change();
        logic [PW-1:0] e2, e4;
        start_frame(2'd0, 1'b0);
        write_line(3, 24'h102030, 24'h203040);
        mode = 2'd1;
        swap_line();
        for (int i = 0; i <= 8; i++) begin
            pulse_out(i == 0, 0);
            e2 = q2.pop_front(); e4 = q4.pop_front(); checks += 2;
            if (pxl_out2 !== e2) begin errors++; $display("FAIL midframe x2 i%0d: got %h want %h", i, pxl_out2, e2); end
            if (pxl_out4 !== e4) begin errors++; $display("FAIL midframe x4 i%0d: got %h want %h", i, pxl_out4, e4); end
        end
        // coincident line and frame edges: the replayed line must be black
        start_frame(2'd1, 1'b1);
        for (int i = 0; i <= 6; i++) begin
            pulse_out(i == 0, 0);
            e2 = q2.pop_front(); e4 = q4.pop_front(); checks += 2;
            if (pxl_out2 !== e2) begin errors++; $display("FAIL frame_black x2 i%0d: got %h want %h", i, pxl_out2, e2); end
            if (pxl_out4 !== e4) begin errors++; $display("FAIL frame_black x4 i%0d: got %h want %h", i, pxl_out4, e4); end
        end
        write_line(3, 24'h102030, 24'h203040);
        swap_line();
        for (int i = 0; i <= 12; i++) begin
            pulse_out(i == 0, 0);
            e2 = q2.pop_front(); e4 = q4.pop_front(); checks += 2;
            if (pxl_out2 !== e2) begin errors++; $display("FAIL newmode x2 i%0d: got %h want %h", i, pxl_out2, e2); end
            if (pxl_out4 !== e4) begin errors++; $display("FAIL newmode x4 i%0d: got %h want %h", i, pxl_out4, e4); end
        end
    endtask

    initial begin
        test_reset();
        test_nearest();
        test_hblend();
        test_scanline();
        test_back_to_back();
        test_saturate();
        test_mode_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_scaler.md
# line_scaler

Parametrised integer pixel scaler for the video output path. Each input line is captured into a ping-pong line buffer, and the previous complete line is replayed SCALE times horizontally and vertically. Four output modes are available: nearest, horizontal linear blend, scanline darkening, and blend with scanlines. It sits between the core's pixel output and the frame scan-doubler, replacing the fixed 2x filter wherever a plain or scanline-shaded 2x/4x image is required.

## Interface
- LENGTH, 256: max input pixels per line; power of two.
- CW, 8: bits per colour channel.
- CH, 3: channel count (1 = mono, 3 = RGB); pixel width PW = CH*CW.
- SCALE, 2: scale factor; legal values 2 or 4 only, anything else is an elaboration error.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- ce_in  in  1  input pixel enable.
- pxl_in  in  PW  input pixel, channel 0 in LSBs.
- line_start  in  1  high during input hblank; a rising edge sampled on ce_in starts a new line.
- frame_start  in  1  high during input vblank; a rising edge sampled on ce_in starts a new frame.
- mode  in  2  0 nearest, 1 hblend, 2 scanline, 3 hblend+scanline.
- ce_out  in  1  output pixel enable; consecutive pulses must be at least 2 clk apart.
- hblank_out  in  1  output blanking.
- row_sel  in  2  output sub-row 0..SCALE-1.
- pxl_out  out  PW  output pixel, registered.

## Operation
- Writer: on a line_start rising edge, it toggles wr_buf, stores last_len <= wr_addr, and sets wr_addr = 0. The pixel on that same ce_in is written to address 0 of the new buffer. Each subsequent ce_in writes pxl_in at wr_addr, then increments it. wr_addr saturates at LENGTH, and extra pixels are dropped.
- Frame: on a frame_start rising edge, last_len <= 0. The first output line of a frame is therefore black. mode is latched into mode_q on the same edge.
- Reader: on each ce_out with hblank_out=1, it latches rd_buf <= ~wr_buf and rd_len <= last_len, clears p and s, sets pxl_out = 0, and prefetches P[0] and P[1].
- Reader, active period: on each ce_out with hblank_out=0, it emits pixel (p,s), then increments s. When s wraps at SCALE-1, s returns to 0 and p increments. Once p >= rd_len, the output is 0, and p saturates at LENGTH-1.
- Neighbour: P[p+1] is taken as P[p] when p = rd_len-1.
- Nearest: out = P[p].
- Hblend, per channel: out = (P[p]*(SCALE-s) + P[p+1]*s) >> log2(SCALE), truncated. The intermediate width is CW+2.
- Scanline: when row_sel == SCALE-1, each channel of the mode result is shifted right by 1.
- rst: all counters clear, wr_buf = 0, last_len = rd_len = 0, mode_q = 0, pxl_out = 0.
- Line timing: upstream must issue line_start so that the reader's buffer is not rewritten during its active period. On violation, pixel data is undefined, but the counters recover at the next hblank_out.

## Timing
- The buffer RAM has 1-cycle read latency. The reader keeps cur/nxt registers, issues the fetch of P[p+2] on the clk after p advances, and has it ready before the next ce_out.
- pxl_out updates on the ce_out clock edge. The first active ce_out after hblank_out falls shows pixel (0,0), so the latency from ce_out to the visible pixel is 0 ce_out periods.
- A written pixel is visible to the reader only after the next line_start swap, i.e. a minimum of one input line of latency.
- Simultaneous line_start and frame_start edges: both actions apply, and last_len is forced to 0.

## Structure
- Package scaler_pkg: mode localparams (MODE_NEAREST, MODE_HBLEND, MODE_SCAN, MODE_BOTH), the SCALE legality check, and the channel blend function.
- Sub-module line_scaler_buf: simple dual-port RAM, LENGTH x PW, registered read. It is instantiated twice (ping-pong); wr_buf selects the write enable and rd_buf selects the output mux.

## Test plan
- Reset, then ce_out pulses → pxl_out = 0 throughout the first line; mode_q = 0.
- SCALE=2, mode 0, line 0x10,0x20,0x30, then swap → output 0x10,0x10,0x20,0x20,0x30,0x30, then 0 beyond rd_len.
- SCALE=4, mode 1, P0 = 0x00, P1 = 0x80 (CW=8) → outputs 0x00,0x20,0x40,0x60, then 0x80 x4 (last pixel self-neighbour).
- Mode 2, pixel 0xFF, row_sel 0 vs 1 (SCALE=2) → 0xFF on row 0, 0x7F on row 1.
- Write LENGTH+5 pixels → last_len = LENGTH; pixel LENGTH-1 is intact; no wrap overwrite of address 0.
- Change mode mid-frame → no effect until the next frame_start edge; frame_start makes the first output line 0.
